// File: rtl/noise_patgen.sv
// Test-pattern video generator: sync/enable timing plus black, checkerboard, binary or gray LFSR noise.
// Latency: outputs lag the raster counters by one cycle; no backpressure (free-running pixel stream).
module noise_patgen #(
    parameter int               H_SYNCLEN    = 62,
    parameter int               H_BACKPORCH  = 60,
    parameter int               H_ACTIVE     = 720,
    parameter int               H_TOTAL      = 858,
    parameter int               V_SYNCLEN    = 6,
    parameter int               V_BACKPORCH  = 30,
    parameter int               V_ACTIVE     = 480,
    parameter int               V_TOTAL      = 525,
    parameter int               H_BORDER     = 104,
    parameter int               V_BORDER     = 112,
    parameter logic [7:0]       BORDER_LEVEL = 8'h50,
    parameter int               LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAP_MASK    = 16'hB400
) (
    input  logic       clk27,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [3:0] scroll_speed,
    output logic [7:0] R_out,
    output logic [7:0] G_out,
    output logic [7:0] B_out,
    output logic       HSYNC_out,
    output logic       VSYNC_out,
    output logic       PCLK_out,
    output logic       ENABLE_out,
    output logic [7:0] frame_cnt,
    output logic       frame_start
);

    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int X_START = H_SYNCLEN + H_BACKPORCH;
    localparam int Y_START = V_SYNCLEN + V_BACKPORCH;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNCLEN);
    localparam logic [HW-1:0] X_ACT_BEG  = HW'(X_START);
    localparam logic [HW-1:0] X_ACT_END  = HW'(X_START + H_ACTIVE);
    localparam logic [HW-1:0] X_PAT_BEG  = HW'(X_START + H_BORDER);
    localparam logic [HW-1:0] X_PAT_END  = HW'(X_START + H_ACTIVE - H_BORDER);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNCLEN);
    localparam logic [VW-1:0] Y_ACT_BEG  = VW'(Y_START);
    localparam logic [VW-1:0] Y_ACT_END  = VW'(Y_START + V_ACTIVE);
    localparam logic [VW-1:0] Y_PAT_BEG  = VW'(Y_START + V_BORDER);
    localparam logic [VW-1:0] Y_PAT_END  = VW'(Y_START + V_ACTIVE - V_BORDER);
    localparam logic [VW-1:0] V_ONE      = VW'(1);

    // XNOR feedback keeps the all-zero reset state legal; all-ones is the lock-up state.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ~(^(q & TAP_MASK))};
    endfunction

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [1:0]        mode_q;
    logic [3:0]        step_cnt;
    logic [LFSR_W-1:0] frame_lfsr;
    logic [LFSR_W-1:0] pix_lfsr;

    logic h_last;
    logic v_last;
    logic frame_wrap;
    logic in_act;
    logic in_pat;
    logic [7:0] level;

    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign frame_wrap = h_last && v_last;

    assign in_act = (h_cnt >= X_ACT_BEG) && (h_cnt < X_ACT_END) &&
                    (v_cnt >= Y_ACT_BEG) && (v_cnt < Y_ACT_END);
    assign in_pat = (h_cnt >= X_PAT_BEG) && (h_cnt < X_PAT_END) &&
                    (v_cnt >= Y_PAT_BEG) && (v_cnt < Y_PAT_END);

    assign PCLK_out = clk27;

    always_ff @(posedge clk27) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // Mode and speed take effect only at the frame boundary so a frame is never mixed.
    always_ff @(posedge clk27) begin
        if (reset) begin
            mode_q     <= 2'd0;
            step_cnt   <= 4'd0;
            frame_lfsr <= '0;
        end else if (frame_wrap) begin
            mode_q   <= mode;
            step_cnt <= scroll_speed;
        end else if ((v_cnt == '0) && (step_cnt != 4'd0)) begin
            frame_lfsr <= lfsr_next(frame_lfsr);
            step_cnt   <= step_cnt - 4'd1;
        end
    end

    // Scrolling comes from restarting each frame at a seed advanced scroll_speed steps.
    always_ff @(posedge clk27) begin
        if (reset) begin
            pix_lfsr <= '0;
        end else if ((h_cnt == '0) && (v_cnt == V_ONE)) begin
            pix_lfsr <= frame_lfsr;
        end else if (in_pat) begin
            pix_lfsr <= lfsr_next(pix_lfsr);
        end
    end

    always_comb begin
        level = BORDER_LEVEL;
        if (in_pat) begin
            case (mode_q)
                2'd0:    level = 8'h00;
                2'd1:    level = {8{h_cnt[0] ^ v_cnt[0]}};
                2'd2:    level = {8{pix_lfsr[0]}};
                default: level = pix_lfsr[7:0];
            endcase
        end
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            HSYNC_out   <= 1'b0;
            VSYNC_out   <= 1'b0;
            ENABLE_out  <= 1'b0;
            R_out       <= 8'h00;
            G_out       <= 8'h00;
            B_out       <= 8'h00;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            HSYNC_out   <= (h_cnt >= H_SYNC_END);
            VSYNC_out   <= (v_cnt >= V_SYNC_END);
            ENABLE_out  <= in_act;
            R_out       <= in_act ? level : 8'h00;
            G_out       <= in_act ? level : 8'h00;
            B_out       <= in_act ? level : 8'h00;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
